// File: rtl/ui_config_sequencer.sv
// Debounces UI change triggers, snapshots the switch bank and writes its four
// nibble fields to the config bank in order. Optional: UI_CFG_SKIP_UNCHANGED_EN.
module ui_config_sequencer #(
  parameter int SETTLE_CYCLES = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] sw_in,
  input  logic        update_trig_in,
  input  logic        cfg_ready_in,
  output logic        cfg_valid_out,
  output logic [1:0]  cfg_addr_out,
  output logic [3:0]  cfg_data_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             pending;
  logic [15:0]      snap;
  logic [3:0]       cur_field;
  logic             skip_cur;
  logic             advance;

  function automatic logic [3:0] field_sel(input logic [15:0] word, input logic [1:0] k);
    return word[{k, 2'b00} +: 4];
  endfunction

  assign cur_field = field_sel(snap, idx);

`ifdef UI_CFG_SKIP_UNCHANGED_EN
  logic [15:0] shadow;
  logic        accept;

  assign skip_cur = (cur_field == field_sel(shadow, idx));
  assign accept   = (state == WRITE) && !skip_cur && cfg_ready_in;

  // Shadow mirrors what the config bank actually holds.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shadow <= '0;
    end else if (accept) begin
      shadow[{idx, 2'b00} +: 4] <= cur_field;
    end
  end
`else
  assign skip_cur = 1'b0;
`endif

  // A skipped field advances without a handshake.
  assign advance = (state == WRITE) && (skip_cur || cfg_ready_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (update_trig_in) state_nxt = SETTLE;
      SETTLE:  if (!update_trig_in && (cnt == CNT_LAST)) state_nxt = WRITE;
      WRITE:   if (advance && (idx == 2'd3)) state_nxt = DONE;
      DONE:    state_nxt = (pending || update_trig_in) ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt     <= '0;
      idx     <= '0;
      pending <= 1'b0;
      snap    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (update_trig_in) cnt <= '0;
        end
        SETTLE: begin
          if (update_trig_in) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            snap <= sw_in;
            idx  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          if (update_trig_in) pending <= 1'b1;
          if (advance) idx <= idx + 1'b1;
        end
        DONE: begin
          cnt     <= '0;
          pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_valid_out = 1'b0;
    cfg_addr_out  = '0;
    cfg_data_out  = '0;
    busy_out      = (state != IDLE);
    done_out      = (state == DONE);
    if ((state == WRITE) && !skip_cur) begin
      cfg_valid_out = 1'b1;
      cfg_addr_out  = idx;
      cfg_data_out  = cur_field;
    end
  end

endmodule

// File: tb/tb_ui_config_sequencer.sv
// Bench for ui_config_sequencer: cycle table for the basic commit, scoreboard of
// expected config writes, hand sequences for restart, stall, pending and reset.
module tb_ui_config_sequencer;

  localparam int SC = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] sw_in;
  logic        update_trig_in;
  logic        cfg_ready_in;
  logic        cfg_valid_out;
  logic [1:0]  cfg_addr_out;
  logic [3:0]  cfg_data_out;
  logic        busy_out;
  logic        done_out;

  always #5 clk_in = ~clk_in;

  ui_config_sequencer #(.SETTLE_CYCLES(SC)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sw_in         (sw_in),
    .update_trig_in(update_trig_in),
    .cfg_ready_in  (cfg_ready_in),
    .cfg_valid_out (cfg_valid_out),
    .cfg_addr_out  (cfg_addr_out),
    .cfg_data_out  (cfg_data_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  typedef struct {
    logic       trig;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_addr;
    logic [3:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t        vt[10];
  logic [5:0]  exp_q[$];
  logic [15:0] tb_shadow;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          d0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected writes of one commit; unchanged fields drop out when skipping is built in.
  task automatic push_commit(input logic [15:0] sw);
    logic [3:0] f;
    for (int k = 0; k < 4; k++) begin
      f = sw[4*k +: 4];
`ifdef UI_CFG_SKIP_UNCHANGED_EN
      if (f == tb_shadow[4*k +: 4]) continue;
`endif
      exp_q.push_back({k[1:0], f});
      tb_shadow[4*k +: 4] = f;
    end
  endtask

  // Scoreboard and done counting happen mid-cycle, before the edge that accepts.
  task automatic step();
    logic [5:0] e;
    @(negedge clk_in);
    if (!rst_in && cfg_valid_out && cfg_ready_in) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, required none", cfg_addr_out, cfg_data_out);
      end else begin
        e = exp_q.pop_front();
        chk("sb_write", {cfg_addr_out, cfg_data_out}, e);
      end
    end
    if (done_out) done_cnt++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_valid_addr(input logic [1:0] a, input int max, input string name);
    int i = 0;
    while (!(cfg_valid_out && cfg_addr_out == a) && i < max) begin
      step();
      i++;
    end
    chk(name, int'(cfg_valid_out && cfg_addr_out == a), 1);
  endtask

  task automatic wait_done(input int max, input string name);
    int i = 0;
    while (!done_out && i < max) begin
      step();
      i++;
    end
    chk(name, int'(done_out), 1);
  endtask

  task automatic commit(input logic [15:0] sw, input string name);
    sw_in = sw;
    update_trig_in = 1'b1;
    push_commit(sw);
    step();
    update_trig_in = 1'b0;
    wait_done(30, name);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //       trig  rdy  vld  addr  data   busy done
    vt[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b1, 1'b1, 2'd2, 4'h3, 1'b1, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b1, 2'd3, 4'h4, 1'b1, 1'b0};
    vt[8] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1};
    vt[9] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0};

    rst_in = 1'b1;
    sw_in = 16'hFFFF;
    update_trig_in = 1'b0;
    cfg_ready_in = 1'b1;
    tb_shadow = 16'h0000;
    step();
    step();
    chk("rst_valid", int'(cfg_valid_out), 0);
    chk("rst_addr", int'(cfg_addr_out), 0);
    chk("rst_data", int'(cfg_data_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    rst_in = 1'b0;
    step();

    // Basic commit, cycle by cycle.
    sw_in = 16'h4321;
    for (int i = 0; i < 10; i++) begin
      update_trig_in = vt[i].trig;
      cfg_ready_in = vt[i].ready;
      if (vt[i].trig) push_commit(sw_in);
      step();
      chk($sformatf("vec%0d_valid", i), int'(cfg_valid_out), int'(vt[i].exp_valid));
      chk($sformatf("vec%0d_busy", i), int'(busy_out), int'(vt[i].exp_busy));
      chk($sformatf("vec%0d_done", i), int'(done_out), int'(vt[i].exp_done));
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_addr", i), int'(cfg_addr_out), int'(vt[i].exp_addr));
        chk($sformatf("vec%0d_data", i), int'(cfg_data_out), int'(vt[i].exp_data));
      end
    end
    chk("basic_sb_empty", exp_q.size(), 0);

    // Retrigger two cycles in restarts debounce and captures the new switches.
    sw_in = 16'h1111;
    update_trig_in = 1'b1;
    step();
    update_trig_in = 1'b0;
    step();
    sw_in = 16'h2468;
    update_trig_in = 1'b1;
    push_commit(16'h2468);
    step();
    update_trig_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("restart_quiet%0d", i), int'(cfg_valid_out), 0);
    end
    step();
    chk("restart_valid", int'(cfg_valid_out), 1);
    chk("restart_data0", int'(cfg_data_out), 8);
    wait_done(10, "restart_done");
    step();
    chk("restart_idle", int'(busy_out), 0);
    chk("restart_sb_empty", exp_q.size(), 0);

    // Downstream stall at index 1.
    sw_in = 16'h8975;
    cfg_ready_in = 1'b0;
    update_trig_in = 1'b1;
    push_commit(16'h8975);
    step();
    update_trig_in = 1'b0;
    wait_valid_addr(2'd0, 10, "stall_first_valid");
    cfg_ready_in = 1'b1;
    step();
    cfg_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), int'(cfg_valid_out), 1);
      chk($sformatf("stall%0d_addr", i), int'(cfg_addr_out), 1);
      chk($sformatf("stall%0d_data", i), int'(cfg_data_out), 7);
      step();
    end
    chk("stall_hold_addr", int'(cfg_addr_out), 1);
    cfg_ready_in = 1'b1;
    step();
    chk("stall_release_addr", int'(cfg_addr_out), 2);
    chk("stall_release_data", int'(cfg_data_out), 9);
    wait_done(10, "stall_done");
    step();
    chk("stall_idle", int'(busy_out), 0);
    chk("stall_sb_empty", exp_q.size(), 0);

    // Trigger during WRITE becomes pending; old snapshot finishes first.
    sw_in = 16'h1234;
    update_trig_in = 1'b1;
    push_commit(16'h1234);
    step();
    update_trig_in = 1'b0;
    wait_valid_addr(2'd1, 10, "pend_reach_idx1");
    d0 = done_cnt;
    sw_in = 16'hAAAA;
    update_trig_in = 1'b1;
    push_commit(16'hAAAA);
    step();
    update_trig_in = 1'b0;
    wait_done(10, "pend_first_done");
    step();
    chk("pend_settle_busy", int'(busy_out), 1);
    chk("pend_settle_valid", int'(cfg_valid_out), 0);
    wait_done(20, "pend_second_done");
    step();
    chk("pend_idle", int'(busy_out), 0);
    chk("pend_done_pulses", done_cnt - d0, 2);
    chk("pend_sb_empty", exp_q.size(), 0);

    // Trigger landing in the DONE cycle itself.
    sw_in = 16'h5555;
    update_trig_in = 1'b1;
    push_commit(16'h5555);
    step();
    update_trig_in = 1'b0;
    wait_done(20, "indone_first_done");
    sw_in = 16'h7777;
    update_trig_in = 1'b1;
    push_commit(16'h7777);
    step();
    update_trig_in = 1'b0;
    chk("indone_settle_busy", int'(busy_out), 1);
    chk("indone_settle_valid", int'(cfg_valid_out), 0);
    wait_done(20, "indone_second_done");
    step();
    chk("indone_idle", int'(busy_out), 0);
    chk("indone_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a write sequence.
    sw_in = 16'h6789;
    update_trig_in = 1'b1;
    push_commit(16'h6789);
    step();
    update_trig_in = 1'b0;
    wait_valid_addr(2'd2, 10, "rstmid_reach_idx2");
    #1;
    rst_in = 1'b1;
    #1;
    chk("rstmid_valid", int'(cfg_valid_out), 0);
    chk("rstmid_addr", int'(cfg_addr_out), 0);
    chk("rstmid_data", int'(cfg_data_out), 0);
    chk("rstmid_busy", int'(busy_out), 0);
    chk("rstmid_done", int'(done_out), 0);
    exp_q.delete();
    tb_shadow = 16'h0000;
    step();
    step();
    rst_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rstmid_after%0d_busy", i), int'(busy_out), 0);
      chk($sformatf("rstmid_after%0d_valid", i), int'(cfg_valid_out), 0);
    end

    // Two commits differing in one field.
    commit(16'h1111, "skip_first_done");
    commit(16'h1151, "skip_second_done");
    chk("skip_idle", int'(busy_out), 0);
    chk("skip_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
